// File: rtl/mem_port_arbiter.sv
// Shares one memory port between I/D line bursts (D priority, streak-bounded); grant 1 cycle after request,
// LINE_WORDS acked beats then a 1-cycle DONE; a missing mem_ack holds the burst indefinitely.
module mem_port_arbiter #(
   parameter int LINE_WORDS   = 4,
   parameter int MAX_D_STREAK = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req,
   input  logic [29:0] i_addr,
   output logic [31:0] i_rdata,
   output logic        i_rvalid,
   output logic        i_done,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [29:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_wready,
   output logic [31:0] d_rdata,
   output logic        d_rvalid,
   output logic        d_done,
   output logic        mem_req,
   output logic        mem_we,
   output logic [29:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic [1:0]  owner,
   output logic        pipe_hold
);
   localparam int WB = $clog2(LINE_WORDS);
   localparam int SB = $clog2(MAX_D_STREAK + 1);
   localparam logic [29:0] LOW_MASK = 30'(LINE_WORDS - 1);

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

   state_t        state;
   state_t        state_nxt;
   logic [WB-1:0] word_cnt;
   logic [SB-1:0] streak;
   logic [29:0]   base;
   logic          we_lat;
   logic [1:0]    owner_lat;
   logic          grant_i;
   logic          grant_d;
   logic          busy;
   logic          last_beat;

   assign busy      = (state == BUSY_I) || (state == BUSY_D);
   assign last_beat = (word_cnt == WB'(LINE_WORDS - 1));

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // D wins unless I is waiting and D has already used up its streak allowance.
   always_comb begin
      state_nxt = state;
      grant_i   = 1'b0;
      grant_d   = 1'b0;
      case (state)
         IDLE: begin
            if (d_req && (!i_req || (streak < SB'(MAX_D_STREAK)))) begin
               state_nxt = BUSY_D;
               grant_d   = 1'b1;
            end else if (i_req) begin
               state_nxt = BUSY_I;
               grant_i   = 1'b1;
            end
         end
         BUSY_I, BUSY_D: if (mem_ack && last_beat) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         word_cnt  <= '0;
         streak    <= '0;
         base      <= '0;
         we_lat    <= 1'b0;
         owner_lat <= 2'b00;
      end else begin
         if (grant_i || grant_d) begin
            base      <= (grant_d ? d_addr : i_addr) & ~LOW_MASK;
            we_lat    <= grant_d & d_we;
            word_cnt  <= '0;
            owner_lat <= grant_d ? 2'b10 : 2'b01;
         end else if (busy && mem_ack) begin
            word_cnt  <= word_cnt + 1'b1;
         end
         if (grant_i)      streak <= '0;
         else if (grant_d) streak <= i_req ? streak + 1'b1 : '0;
      end
   end

   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      owner     = 2'b00;
      i_rvalid  = 1'b0;
      d_rvalid  = 1'b0;
      d_wready  = 1'b0;
      i_done    = 1'b0;
      d_done    = 1'b0;
      pipe_hold = 1'b0;
      case (state)
         IDLE: pipe_hold = i_req | d_req;
         BUSY_I: begin
            mem_req   = 1'b1;
            mem_addr  = base | 30'(word_cnt);
            owner     = 2'b01;
            i_rvalid  = mem_ack;
            pipe_hold = 1'b1;
         end
         BUSY_D: begin
            mem_req   = 1'b1;
            mem_we    = we_lat;
            mem_addr  = base | 30'(word_cnt);
            owner     = 2'b10;
            d_rvalid  = mem_ack & ~we_lat;
            d_wready  = mem_ack & we_lat;
            pipe_hold = 1'b1;
         end
         DONE: begin
            i_done = (owner_lat == 2'b01);
            d_done = (owner_lat == 2'b10);
         end
         default: ;
      endcase
   end

   assign i_rdata   = mem_rdata;
   assign d_rdata   = mem_rdata;
   assign mem_wdata = d_wdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: requester tasks queue expected bursts, a monitor replays
// the arbitration and burst timeline at transaction level and checks every cycle.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
   localparam int LW   = 4;
   localparam int MAXS = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_req = 1'b0;
   logic [29:0] i_addr = '0;
   logic [31:0] i_rdata;
   logic        i_rvalid;
   logic        i_done;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [29:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic        d_wready;
   logic [31:0] d_rdata;
   logic        d_rvalid;
   logic        d_done;
   logic        mem_req;
   logic        mem_we;
   logic [29:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        mem_ack = 1'b0;
   logic [1:0]  owner;
   logic        pipe_hold;

   always #5 clk = ~clk;

   mem_port_arbiter #(.LINE_WORDS(LW), .MAX_D_STREAK(MAXS)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_done(i_done),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wready(d_wready),
      .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_done(d_done),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .owner(owner), .pipe_hold(pipe_hold)
   );

   typedef struct packed {
      logic [29:0]          base;
      logic                 we;
      logic [LW-1:0][31:0]  words;
   } txn_t;

   txn_t iq[$];
   txn_t dq[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   ack_mode = 0;
   bit   alt = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Memory model: ack pattern selected by ack_mode, fresh random read data every cycle.
   initial begin
      forever begin
         @(posedge clk); #1;
         mem_rdata = $urandom;
         case (ack_mode)
            0: mem_ack = 1'b1;
            1: begin alt = ~alt; mem_ack = alt; end
            2: mem_ack = ($urandom_range(0, 2) != 0);
            default: mem_ack = 1'b0;
         endcase
      end
   end

   task automatic do_i(input logic [29:0] a);
      txn_t t;
      bit   dn;
      t.base  = a & ~30'(LW - 1);
      t.we    = 1'b0;
      t.words = '0;
      iq.push_back(t);
      i_addr = a;
      i_req  = 1'b1;
      dn     = 1'b0;
      for (int c = 0; c < 400 && !dn; c++) begin
         @(negedge clk); dn = i_done;
         @(posedge clk); #1;
      end
      check("i_done_seen", 64'(dn), 64'(1));
      i_req = 1'b0;
   endtask

   task automatic do_d(input logic [29:0] a, input logic we);
      txn_t t;
      bit   dn;
      bit   wr;
      bit   rs;
      int   wk;
      t.base = a & ~30'(LW - 1);
      t.we   = we;
      for (int j = 0; j < LW; j++) t.words[j] = $urandom;
      dq.push_back(t);
      d_addr  = a;
      d_we    = we;
      wk      = 0;
      d_wdata = t.words[0];
      d_req   = 1'b1;
      dn      = 1'b0;
      for (int c = 0; c < 400 && !dn; c++) begin
         @(negedge clk); dn = d_done; wr = d_wready; rs = rst;
         @(posedge clk); #1;
         if (rs) wk = 0;
         else if (wr) wk++;
         d_wdata = t.words[wk % LW];
      end
      check("d_done_seen", 64'(dn), 64'(1));
      d_req = 1'b0;
   endtask

   // Monitor: phase 0 idle/arbitrate, 1 burst in progress, 2 done cycle.
   initial begin
      int   ph;
      int   cur;
      int   k;
      int   ms;
      txn_t t;
      ph = 0; cur = 0; k = 0; ms = 0; t = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            ph = 0; cur = 0; k = 0; ms = 0;
            continue;
         end
         case (ph)
            0: begin
               check("idle_outputs", 64'({mem_req, owner, mem_we, i_rvalid, d_rvalid, d_wready, i_done, d_done}), 64'(0));
               check("idle_hold", 64'(pipe_hold), 64'(i_req | d_req));
               cur = 0;
               if (d_req && (!i_req || ms < MAXS)) begin
                  cur = 2;
                  ms  = i_req ? ms + 1 : 0;
               end else if (i_req) begin
                  cur = 1;
                  ms  = 0;
               end
               if (cur != 0) begin
                  if ((cur == 1 ? iq.size() : dq.size()) == 0) begin
                     check("queue_empty_at_grant", 64'(1), 64'(0));
                     cur = 0;
                  end else begin
                     t  = (cur == 1) ? iq[0] : dq[0];
                     k  = 0;
                     ph = 1;
                  end
               end
            end
            1: begin
               check("busy_port", 64'({mem_req, owner, mem_we, mem_addr}),
                     64'({1'b1, (cur == 2) ? 2'b10 : 2'b01, t.we, t.base + 30'(k)}));
               check("busy_hold", 64'(pipe_hold), 64'(1));
               if (mem_ack) begin
                  check("beat_pulses", 64'({i_rvalid, d_rvalid, d_wready, i_done, d_done}),
                        64'({cur == 1, cur == 2 && !t.we, cur == 2 && t.we, 2'b00}));
                  if (cur == 1)  check("i_rdata", 64'(i_rdata), 64'(mem_rdata));
                  else if (t.we) check("mem_wdata", 64'(mem_wdata), 64'(t.words[k]));
                  else           check("d_rdata", 64'(d_rdata), 64'(mem_rdata));
                  k++;
                  if (k == LW) ph = 2;
               end else begin
                  check("stall_pulses", 64'({i_rvalid, d_rvalid, d_wready, i_done, d_done}), 64'(0));
               end
            end
            default: begin
               check("done_outputs", 64'({mem_req, mem_we, i_rvalid, d_rvalid, d_wready, pipe_hold}), 64'(0));
               check("done_pulse", 64'({i_done, d_done}), 64'({cur == 1, cur == 2}));
               if (cur == 1) t = iq.pop_front();
               else          t = dq.pop_front();
               ph  = 0;
               cur = 0;
            end
         endcase
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) begin @(posedge clk); #1; end

      // Single I refill, zero-wait memory.
      ack_mode = 0;
      do_i(30'h101);

      // Simultaneous requests: D first, then I.
      fork
         do_i(30'($urandom));
         do_d(30'($urandom), 1'b0);
      join

      // I held while D keeps re-requesting: streak limit forces I in.
      fork
         do_i(30'($urandom));
         repeat (5) do_d(30'($urandom), 1'($urandom_range(0, 1)));
      join

      // D write-back with acks on alternate cycles.
      ack_mode = 1;
      do_d(30'h200, 1'b1);

      // No requests, spurious acks.
      ack_mode = 2;
      repeat (10) begin @(posedge clk); #1; end

      // Reset in the middle of an I burst, after two beats.
      ack_mode = 0;
      fork
         do_i(30'h3C5);
         begin
            int n;
            n = 0;
            for (int c = 0; c < 50 && n < 2; c++) begin
               @(negedge clk);
               if (i_rvalid) n++;
            end
            @(posedge clk); #1 rst = 1'b1;
            @(posedge clk); #1 rst = 1'b0;
         end
      join

      // Random traffic on both sides with random memory stalls.
      ack_mode = 2;
      fork
         for (int r = 0; r < 12; r++) begin
            repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
            do_i(30'($urandom));
         end
         for (int r = 0; r < 12; r++) begin
            repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
            do_d(30'($urandom), 1'($urandom_range(0, 1)));
         end
      join

      repeat (5) begin @(posedge clk); #1; end
      check("queues_drained", 64'(iq.size() + dq.size()), 64'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
